// File: rtl/cpu_clk_ctrl_pkg.sv
// Shared encodings for the CPU clock-enable sequencer: mode selects, sequencer
// states and the debug view of the sequencer.
package cpu_clk_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_HALT = 2'b00,
    MODE_RUN  = 2'b01,
    MODE_DIV  = 2'b10,
    MODE_STEP = 2'b11
  } mode_t;

  typedef enum logic {
    ST_POR    = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    state_t state;
    mode_t  mode;
    logic   db_level;
  } dbg_t;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stability counter.
// A level change is accepted after DB_CYC consecutive cycles of the new value.
module btn_debounce #(
  parameter int DB_CYC = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CW = $clog2(DB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      // Any sample equal to the accepted level restarts the stability window.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_rise  <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Clock-enable and reset sequencer for the CPU: power-on reset stretch, then a
// single-cycle cpu_ce strobe in halt, free-run, divided or step-burst mode.
import cpu_clk_ctrl_pkg::*;

module cpu_clk_ctrl #(
  parameter int DIV_W   = 16,
  parameter int BURST_W = 8,
  parameter int DB_CYC  = 16,
  parameter int POR_CYC = 16,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div,
  input  logic               step_btn,
  input  logic [BURST_W-1:0] burst,
  output logic               cpu_ce,
  output logic               cpu_rst,
  output logic               busy,
  output logic [CNT_W-1:0]   cycle_cnt,
  output dbg_t               dbg
);

  localparam int PW = $clog2(POR_CYC + 1);
  localparam logic [PW-1:0] POR_LAST = PW'(POR_CYC - 1);

  state_t             r_state;
  logic [PW-1:0]      r_por_cnt;
  mode_t              r_mode;
  logic [DIV_W-1:0]   r_dcnt;
  logic [BURST_W-1:0] r_rem;
  logic               r_busy;
  logic               r_ce;
  logic               r_cpu_rst;
  logic [CNT_W-1:0]   r_cycle_cnt;

  state_t             w_state_n;
  logic [PW-1:0]      w_por_cnt_n;
  logic [DIV_W-1:0]   w_dcnt_n;
  logic [BURST_W-1:0] w_rem_n;
  logic               w_busy_n;
  logic               w_ce_n;
  logic               w_cpu_rst_n;
  logic [CNT_W-1:0]   w_cycle_cnt_n;
  logic               w_mode_chg;
  logic [BURST_W-1:0] w_burst_eff;
  logic               w_db_level;
  logic               w_press;

  btn_debounce #(.DB_CYC(DB_CYC)) u_btn_debounce (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_btn   (step_btn),
    .o_level (w_db_level),
    .o_rise  (w_press)
  );

  assign w_mode_chg  = (mode_t'(mode) != r_mode);
  assign w_burst_eff = (burst == '0) ? BURST_W'(1) : burst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_POR;
      r_por_cnt   <= '0;
      r_mode      <= MODE_HALT;
      r_dcnt      <= '0;
      r_rem       <= '0;
      r_busy      <= 1'b0;
      r_ce        <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_cycle_cnt <= '0;
    end else begin
      r_state     <= w_state_n;
      r_por_cnt   <= w_por_cnt_n;
      r_mode      <= mode_t'(mode);
      r_dcnt      <= w_dcnt_n;
      r_rem       <= w_rem_n;
      r_busy      <= w_busy_n;
      r_ce        <= w_ce_n;
      r_cpu_rst   <= w_cpu_rst_n;
      r_cycle_cnt <= w_cycle_cnt_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_por_cnt_n = r_por_cnt;
    w_dcnt_n    = '0;
    w_rem_n     = '0;
    w_busy_n    = 1'b0;
    w_ce_n      = 1'b0;
    w_cpu_rst_n = 1'b1;
    if (r_state == ST_POR) begin
      if (r_por_cnt == POR_LAST) begin
        w_state_n   = ST_ACTIVE;
        w_cpu_rst_n = 1'b0;
      end else begin
        w_por_cnt_n = r_por_cnt + PW'(1);
      end
    end else begin
      w_cpu_rst_n = 1'b0;
      w_dcnt_n    = r_dcnt;
      w_rem_n     = r_rem;
      w_busy_n    = r_busy;
      // The cycle after a mode change is a dead cycle that clears the counters.
      if (w_mode_chg) begin
        w_dcnt_n = '0;
        w_rem_n  = '0;
        w_busy_n = 1'b0;
      end else begin
        case (r_mode)
          MODE_RUN: w_ce_n = 1'b1;
          MODE_DIV: begin
            if (r_dcnt >= div) begin
              w_ce_n   = 1'b1;
              w_dcnt_n = '0;
            end else begin
              w_dcnt_n = r_dcnt + DIV_W'(1);
            end
          end
          MODE_STEP: begin
            // r_rem counts strobes still owed after the one being issued.
            if (r_busy) begin
              if (r_rem != '0) begin
                w_ce_n  = 1'b1;
                w_rem_n = r_rem - BURST_W'(1);
              end else begin
                w_busy_n = 1'b0;
              end
            end else if (w_press) begin
              w_ce_n   = 1'b1;
              w_busy_n = 1'b1;
              w_rem_n  = w_burst_eff - BURST_W'(1);
            end
          end
          default: w_ce_n = 1'b0;
        endcase
      end
    end
    w_cycle_cnt_n = w_cpu_rst_n ? '0 : r_cycle_cnt + CNT_W'(w_ce_n);
  end

  assign cpu_ce       = r_ce;
  assign cpu_rst      = r_cpu_rst;
  assign busy         = r_busy;
  assign cycle_cnt    = r_cycle_cnt;
  assign dbg.state    = r_state;
  assign dbg.mode     = r_mode;
  assign dbg.db_level = w_db_level;

endmodule
